// File: rtl/pkg_salsa.sv
// Shared types and constants for the Salsa20 keystream XOR stage.
package pkg_salsa;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM
  } salsa_xor_state_t;

  localparam int SALSA_BLOCK_BYTES     = 64;
  localparam int SALSA_WORDS_PER_BLOCK = 16;

  // Word index within a keystream block and the index of its final word.
  localparam int                WIDX_W    = $clog2(SALSA_WORDS_PER_BLOCK);
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(SALSA_WORDS_PER_BLOCK - 1);

endpackage

// File: rtl/salsa20_ks_buffer.sv
// Holds one captured 64-byte keystream block and returns the 32-bit
// little-endian word selected by the current word index.
module salsa20_ks_buffer
  import pkg_salsa::*;
(
  input  logic              clk,
  input  logic              capture,
  input  logic [7:0]        ks_block [0:SALSA_BLOCK_BYTES-1],
  input  logic [WIDX_W-1:0] widx,
  output logic [31:0]       ks_word
);

  logic [SALSA_BLOCK_BYTES*8-1:0] ks_q;
  logic [SALSA_BLOCK_BYTES*8-1:0] ks_d;

  // Load the whole block on capture, otherwise hold; byte i lands in bits [8i+7:8i].
  always_comb begin
    // NOTE: default assignment first so every path drives ks_d and no latch is inferred.
    ks_d = ks_q;
    if (capture) begin
      for (int i = 0; i < SALSA_BLOCK_BYTES; i++) begin
        ks_d[8*i +: 8] = ks_block[i];
      end
    end
  end

  // Capture register; contents are only read after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    // NOTE: data storage is left unreset; the FSM guarantees it is written before use.
    // NOTE: non-blocking assignment for all sequential state.
    ks_q <= ks_d;
  end

  // Word w is bytes {4w+3, 4w+2, 4w+1, 4w}, i.e. bits [32w+31:32w].
  assign ks_word = ks_q[{widx, 5'b0} +: 32];

endmodule

// File: rtl/salsa20_stream_xor.sv
// Salsa20 keystream consumer: requests numbered keystream blocks from the core,
// captures them and XORs them into a 32-bit valid/ready stream.
module salsa20_stream_xor
  import pkg_salsa::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic         cfg_keylength,
  input  logic [3:0]   cfg_rounds,
  input  logic [255:0] cfg_key,
  input  logic [63:0]  cfg_nonce,
  input  logic [63:0]  cfg_blkid,
  output logic         ks_start,
  output logic         ks_keylength,
  output logic [3:0]   ks_rounds,
  output logic [255:0] ks_key,
  output logic [63:0]  ks_nonce,
  output logic [63:0]  ks_blkid,
  input  logic         ks_valid,
  input  logic [7:0]   ks_block [0:SALSA_BLOCK_BYTES-1],
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [31:0]  m_data,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic         busy,
  output logic         ctr_wrap
);

  salsa_xor_state_t  state_q, state_d;
  logic              keylength_q, keylength_d;
  logic [3:0]        rounds_q, rounds_d;
  logic [255:0]      key_q, key_d;
  logic [63:0]       nonce_q, nonce_d;
  logic [63:0]       blkid_q, blkid_d;
  logic              start_q, start_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [31:0]       m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              ctr_wrap_q, ctr_wrap_d;

  logic        s_fire;
  logic        blk_done;
  logic        capture;
  logic [31:0] ks_word;

  salsa20_ks_buffer u_ks_buffer (
    .clk      (clk),
    .capture  (capture),
    .ks_block (ks_block),
    .widx     (widx_q),
    .ks_word  (ks_word)
  );

  // Input is accepted only while streaming and the output register can take a word.
  assign s_ready  = (state_q == STREAM) && (!m_valid_q || m_ready);
  assign s_fire   = s_valid && s_ready;
  assign blk_done = s_fire && (s_last || (widx_q == LAST_WIDX));
  assign capture  = (state_q == WAIT) && ks_valid && !cfg_load;

  // Next-state, block-counter and output-register logic; cfg_load is applied last so it wins.
  always_comb begin
    state_d     = state_q;
    keylength_d = keylength_q;
    rounds_d    = rounds_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    blkid_d     = blkid_q;
    widx_d      = widx_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    ctr_wrap_d  = ctr_wrap_q;

    unique case (state_q)
      IDLE:   state_d = IDLE;
      // Leave once the single request pulse has been presented to the core.
      REQ:    if (start_q) state_d = WAIT;
      WAIT:   if (ks_valid) state_d = STREAM;
      STREAM: begin
        if (s_fire) begin
          widx_d = widx_q + 1'b1;
          if (blk_done) begin
            // Leftover words of this block are dropped; the next block is always fresh.
            widx_d  = '0;
            blkid_d = blkid_q + 64'd1;
            if (blkid_q == '1) ctr_wrap_d = 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (s_fire) begin
      m_data_d  = s_data ^ ks_word;
      m_last_d  = s_last;
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (cfg_load) begin
      keylength_d = cfg_keylength;
      rounds_d    = cfg_rounds;
      key_d       = cfg_key;
      nonce_d     = cfg_nonce;
      blkid_d     = cfg_blkid;
      widx_d      = '0;
      ctr_wrap_d  = 1'b0;
      m_valid_d   = 1'b0;
      state_d     = REQ;
    end

    // A request pulse accompanies every entry into REQ but never repeats back to back.
    start_d = (state_d == REQ) && !start_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      keylength_q <= 1'b0;
      rounds_q    <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      blkid_q     <= '0;
      start_q     <= 1'b0;
      widx_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      ctr_wrap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      keylength_q <= keylength_d;
      rounds_q    <= rounds_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      blkid_q     <= blkid_d;
      start_q     <= start_d;
      widx_q      <= widx_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      ctr_wrap_q  <= ctr_wrap_d;
    end
  end

  assign ks_start     = start_q;
  assign ks_keylength = keylength_q;
  assign ks_rounds    = rounds_q;
  assign ks_key       = key_q;
  assign ks_nonce     = nonce_q;
  assign ks_blkid     = blkid_q;
  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign busy         = (state_q == REQ) || (state_q == WAIT);
  assign ctr_wrap     = ctr_wrap_q;

endmodule

// File: doc/salsa20_stream_xor.md
# salsa20_stream_xor

Downstream consumer of the Salsa20 keystream generator. Holds the cipher configuration, drives block requests with an incrementing block counter, and captures each 64-byte keystream block. XORs that keystream into a 32-bit valid/ready data stream, so the same block serves for both encryption and decryption. Sits between the bus-side data FIFOs and the Salsa20Key/Salsa20Hash core.

## Interface
- No parameters. Data width is fixed at 32 bits, so each 64-byte keystream block covers 16 words.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_load` in 1: one-cycle pulse that latches the `cfg_*` inputs and starts a new stream.
- `cfg_keylength` in 1: 1 selects a 32-byte key, 0 a 16-byte key.
- `cfg_rounds` in 4: double-round count, passed through to the core.
- `cfg_key` in 256: key.
- `cfg_nonce` in 64: nonce.
- `cfg_blkid` in 64: initial block counter.
- `ks_start` out 1: one-cycle request pulse to the keystream core.
- `ks_keylength` out 1, `ks_rounds` out 4, `ks_key` out 256, `ks_nonce` out 64, `ks_blkid` out 64: registered copies for the core. They are stable from `ks_start` until `ks_valid`.
- `ks_valid` in 1: keystream block ready.
- `ks_block` in 8×[0:63]: keystream bytes.
- `s_data` in 32, `s_valid` in 1, `s_last` in 1, `s_ready` out 1: input stream.
- `m_data` out 32, `m_valid` out 1, `m_last` out 1, `m_ready` in 1: output stream.
- `busy` out 1: high in REQ or WAIT.
- `ctr_wrap` out 1: sticky flag, set when the block counter wraps from 2^64−1 to 0; cleared by `cfg_load` or `rst`.

## Operation
FSM states: IDLE, REQ, WAIT, STREAM.
- **IDLE:** no configuration held; `s_ready`=0. On `cfg_load`, latch the config, set word index `widx`=0, go to REQ.
- **REQ:** drive `ks_start`=1 for exactly one cycle with the current `ks_blkid`, then go to WAIT.
- **WAIT:** on the first cycle with `ks_valid`=1, capture `ks_block` into a 512-bit keystream register and go to STREAM. `ks_valid` is ignored in every other state.
- **STREAM:** `s_ready` = !`m_valid` || `m_ready`. On each input handshake:
  - `m_data` = `s_data` XOR {ks[4w+3], ks[4w+2], ks[4w+1], ks[4w]}, with w = `widx`. Byte 4w maps to bits [7:0] (little-endian).
  - `m_last` = `s_last`; `m_valid` is set to 1.
  - `widx` increments.
- **Block exhaustion:** when the handshake consumes `widx`=15, or carries `s_last`=1:
  - `ks_blkid` increments by 1, modulo 2^64; on wrap, `ctr_wrap` is set.
  - `widx` returns to 0 and the FSM goes to REQ.
  - Unused keystream words are discarded and never reused.
- **Output register:** clears `m_valid` on an `m_ready` handshake when no new word loads the same cycle. A simultaneous load and drain keeps `m_valid`=1.
- **`cfg_load` priority:** accepted in any state and wins over every other event that cycle.
  - `m_valid` is cleared, dropping any pending output word.
  - An in-flight core result is discarded: the FSM goes to REQ, then waits for the next `ks_valid` after the new `ks_start`.
- **Reset outputs:** `m_valid`, `m_last`, `s_ready`, `ks_start`, `busy`, `ctr_wrap` = 0; `m_data`, `ks_*` buses = 0; state = IDLE.

## Timing
- `cfg_load` at cycle t gives `ks_start` at t+1. The first `s_ready` comes at ks_valid_cycle+1.
- Throughput is 1 word per cycle within a block. Inter-block bubble = 2 cycles + core latency (REQ, WAIT, core).
- Input handshake at t gives `m_valid` at t+1; one register stage.
- `m_data`/`m_last` hold stable while `m_valid` && !`m_ready`.
- `ks_start` is never asserted on two consecutive cycles.

## Structure
- Package `pkg_salsa`:
  - `typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} salsa_xor_state_t`.
  - Constants `SALSA_BLOCK_BYTES`=64 and `SALSA_WORDS_PER_BLOCK`=16.
- The keystream core is not instantiated here; the top level connects `ks_*` to Salsa20Key.
- One natural sub-module: `salsa20_ks_buffer`. It holds the 512-bit capture register and the word selector (`widx` → 32-bit little-endian word).

## Test plan
- **Basic block:** key=0x00..1F (32-byte), nonce=0, `cfg_blkid`=0, 16 words of `s_data`=0 → `m_data` equals keystream block 0 as little-endian words. Exactly one `ks_start`, with `ks_blkid`=0; the next `ks_start` carries `ks_blkid`=1.
- **Round trip:** 40-word random plaintext, last on word 39 → encrypt then decrypt gives the original plaintext. Three `ks_start` pulses, with blkid 0, 1, 2; blkid 3 is requested after `s_last`.
- **Backpressure:** hold `m_ready`=0 for 5 cycles mid-block → `s_ready`=0 after one word is buffered. `m_data` is stable, and there is no loss or duplication.
- **Counter wrap:** `cfg_blkid`=0xFFFF_FFFF_FFFF_FFFF with 17 words → the second request has `ks_blkid`=0 and `ctr_wrap`=1.
- **Abort:** `cfg_load` in WAIT with a new nonce, while a stale `ks_valid` pulse is injected 1 cycle later → the stale pulse is ignored, a new `ks_start` is issued, and the output uses the new keystream.
- **Reset:** `rst` mid-STREAM with `m_valid`=1 → the next cycle shows all outputs zero and state IDLE.
